// File: rtl/axi_w_router_pkg.sv
// Shared AXI definitions for the write-data router: width defines, default
// burst-length width, target-select width and the router FSM state type.
`ifndef AXI_W_ROUTER_PKG_DEFINES
`define AXI_W_ROUTER_PKG_DEFINES
`define AXI_SEL_W 3
`define AXI_LEN_W 4
`endif

package axi_w_router_pkg;

    localparam int unsigned SEL_W     = `AXI_SEL_W;
    localparam int unsigned LEN_W_DEF = `AXI_LEN_W;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StActive = 2'd1,
        StDrain  = 2'd2
    } state_e;

endpackage

// File: rtl/axi_w_skid.sv
// Two-entry registered FIFO that decouples the master W channel from the
// selected slave; used by axi_w_router only when AXI_W_SKID_EN is defined.
module axi_w_skid #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q, rd_ptr_q;
    logic [1:0]       cnt_q;
    logic             push, pop;

    assign in_ready  = (cnt_q != 2'd2);
    assign out_valid = (cnt_q != 2'd0);
    assign empty     = (cnt_q == 2'd0);
    assign out_data  = mem_q[rd_ptr_q];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_q + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: rtl/axi_w_router.sv
// AXI write-data router: steers one master W burst to the slave picked by the
// address channel, generating WLAST locally. Define AXI_W_SKID_EN for a skid buffer.
module axi_w_router
    import axi_w_router_pkg::*;
#(
    parameter int unsigned NUM_S  = 2,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = LEN_W_DEF
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic                      aw_valid,
    input  logic [SEL_W-1:0]          aw_sel,
    input  logic [LEN_W-1:0]          aw_len,
    output logic                      aw_ready,
    input  logic [DATA_W-1:0]         WDATA_M,
    input  logic [DATA_W/8-1:0]       WSTRB_M,
    input  logic                      WLAST_M,
    input  logic                      WVALID_M,
    output logic                      WREADY_M,
    output logic [NUM_S*DATA_W-1:0]   WDATA_S,
    output logic [NUM_S*DATA_W/8-1:0] WSTRB_S,
    output logic [NUM_S-1:0]          WLAST_S,
    output logic [NUM_S-1:0]          WVALID_S,
    input  logic [NUM_S-1:0]          WREADY_S,
    output logic                      busy,
    output logic                      last_err,
    output logic                      dec_err
);

    localparam int unsigned STRB_W = DATA_W / 8;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [LEN_W-1:0]   len_q, len_d, cnt_q, cnt_d;
    logic               last_err_q, last_err_d, dec_err_q, dec_err_d;

    logic               valid_tgt, gen_last, hs, route_en, sel_ready, m_ready;
    logic               s_valid, s_last;
    logic [DATA_W-1:0]  s_data;
    logic [STRB_W-1:0]  s_strb;

    assign valid_tgt = (32'(sel_q) < NUM_S);
    assign gen_last  = (cnt_q == len_q);

`ifdef AXI_W_SKID_EN
    localparam int unsigned BUF_W = DATA_W + STRB_W + 1;

    logic             push, push_ready, pop_valid, buf_empty;
    logic [BUF_W-1:0] pop_data;

    assign push = (state_q == StActive) && valid_tgt && WVALID_M;

    axi_w_skid #(
        .WIDTH(BUF_W)
    ) u_skid (
        .clk      (ACLK),
        .rst      (ARESET),
        .in_valid (push),
        .in_ready (push_ready),
        .in_data  ({WDATA_M, WSTRB_M, gen_last}),
        .out_valid(pop_valid),
        .out_ready(sel_ready),
        .out_data (pop_data),
        .empty    (buf_empty)
    );

    assign s_valid  = pop_valid;
    assign {s_data, s_strb, s_last} = pop_data;
    assign m_ready  = push_ready;
    assign route_en = (state_q != StIdle);
`else
    assign s_valid  = WVALID_M;
    assign s_data   = WDATA_M;
    assign s_strb   = WSTRB_M;
    assign s_last   = gen_last;
    assign m_ready  = sel_ready;
    assign route_en = (state_q == StActive);
`endif

    // Only the latched target sees traffic; an out-of-range sel matches no slave.
    always_comb begin
        WDATA_S   = '0;
        WSTRB_S   = '0;
        WLAST_S   = '0;
        WVALID_S  = '0;
        sel_ready = 1'b0;
        for (int unsigned i = 0; i < NUM_S; i++) begin
            if (route_en && (sel_q == SEL_W'(i))) begin
                WDATA_S[i*DATA_W +: DATA_W] = s_data;
                WSTRB_S[i*STRB_W +: STRB_W] = s_strb;
                WLAST_S[i]                  = s_last;
                WVALID_S[i]                 = s_valid;
                sel_ready                   = WREADY_S[i];
            end
        end
    end

    assign WREADY_M = (state_q == StActive) && (valid_tgt ? m_ready : 1'b1);
    assign hs       = WVALID_M && WREADY_M;
    assign aw_ready = (state_q == StIdle);
    assign busy     = (state_q != StIdle);
    assign last_err = last_err_q;
    assign dec_err  = dec_err_q;

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        last_err_d = 1'b0;
        dec_err_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (aw_valid) begin
                    sel_d   = aw_sel;
                    len_d   = aw_len;
                    cnt_d   = '0;
                    state_d = StActive;
                end
            end
            StActive: begin
                if (hs) begin
                    cnt_d      = cnt_q + LEN_W'(1);
                    last_err_d = (WLAST_M != gen_last);
                    if (gen_last) begin
                        dec_err_d = !valid_tgt;
`ifdef AXI_W_SKID_EN
                        // The final beat was just pushed, so a routed burst always drains.
                        state_d   = valid_tgt ? StDrain : StIdle;
`else
                        state_d   = StIdle;
`endif
                    end
                end
            end
            StDrain: begin
`ifdef AXI_W_SKID_EN
                if (buf_empty) begin
                    state_d = StIdle;
                end
`else
                state_d = StIdle;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q    <= StIdle;
            sel_q      <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            last_err_q <= 1'b0;
            dec_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            last_err_q <= last_err_d;
            dec_err_q  <= dec_err_d;
        end
    end

endmodule

// File: tb/tb_axi_w_router.sv
// Self-checking bench for axi_w_router: vector table, directed corner cases and
// a randomized run against a burst-level model (skid build runs the skid scenario).
module tb_axi_w_router;

    localparam int NUM_S  = 2;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 4;

    logic                      clk;
    logic                      ARESET;
    logic                      aw_valid;
    logic [2:0]                aw_sel;
    logic [LEN_W-1:0]          aw_len;
    logic                      aw_ready;
    logic [DATA_W-1:0]         WDATA_M;
    logic [DATA_W/8-1:0]       WSTRB_M;
    logic                      WLAST_M;
    logic                      WVALID_M;
    logic                      WREADY_M;
    logic [NUM_S*DATA_W-1:0]   WDATA_S;
    logic [NUM_S*DATA_W/8-1:0] WSTRB_S;
    logic [NUM_S-1:0]          WLAST_S;
    logic [NUM_S-1:0]          WVALID_S;
    logic [NUM_S-1:0]          WREADY_S;
    logic                      busy;
    logic                      last_err;
    logic                      dec_err;

    int n_checks = 0;
    int n_err    = 0;

    axi_w_router #(
        .NUM_S (NUM_S),
        .DATA_W(DATA_W),
        .LEN_W (LEN_W)
    ) dut (
        .ACLK    (clk),
        .ARESET  (ARESET),
        .aw_valid(aw_valid),
        .aw_sel  (aw_sel),
        .aw_len  (aw_len),
        .aw_ready(aw_ready),
        .WDATA_M (WDATA_M),
        .WSTRB_M (WSTRB_M),
        .WLAST_M (WLAST_M),
        .WVALID_M(WVALID_M),
        .WREADY_M(WREADY_M),
        .WDATA_S (WDATA_S),
        .WSTRB_S (WSTRB_S),
        .WLAST_S (WLAST_S),
        .WVALID_S(WVALID_S),
        .WREADY_S(WREADY_S),
        .busy    (busy),
        .last_err(last_err),
        .dec_err (dec_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic av, input logic [2:0] sel, input logic [3:0] len,
                          input logic wv, input logic wl, input logic [1:0] rs,
                          input logic [31:0] data);
        aw_valid = av;
        aw_sel   = sel;
        aw_len   = len;
        WVALID_M = wv;
        WLAST_M  = wl;
        WREADY_S = rs;
        WDATA_M  = data;
        WSTRB_M  = 4'hF;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

`ifndef AXI_W_SKID_EN
    typedef struct {
        logic        av;
        logic [2:0]  sel;
        logic [3:0]  len;
        logic        wv;
        logic        wl;
        logic [1:0]  rs;
        logic [31:0] data;
        logic        e_awr;
        logic        e_wrm;
        logic [1:0]  e_wvs;
        logic [1:0]  e_wls;
        logic [63:0] e_wds;
        logic        e_busy;
        logic        e_lerr;
        logic        e_derr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic av, logic [2:0] sel, logic [3:0] len, logic wv, logic wl,
                                logic [1:0] rs, logic [31:0] data, logic e_awr, logic e_wrm,
                                logic [1:0] e_wvs, logic [1:0] e_wls, logic [63:0] e_wds,
                                logic e_busy, logic e_lerr, logic e_derr);
        vec_t v;
        v.av = av; v.sel = sel; v.len = len; v.wv = wv; v.wl = wl; v.rs = rs; v.data = data;
        v.e_awr = e_awr; v.e_wrm = e_wrm; v.e_wvs = e_wvs; v.e_wls = e_wls; v.e_wds = e_wds;
        v.e_busy = e_busy; v.e_lerr = e_lerr; v.e_derr = e_derr;
        return v;
    endfunction

    // Burst-level reference state
    bit m_busy, m_perr, m_pdec, final_b, hs;
    int m_tgt, m_nbeats, m_done;
    logic        e_wrm;
    logic [1:0]  e_wvs, e_wls;
    logic [63:0] e_wd;
    logic [7:0]  e_ws;
`endif

    initial begin
        ARESET = 1'b1;
        set_in(1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 2'b00, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        ARESET = 1'b0;
        #1;
        check("reset aw_ready", aw_ready, 1);
        check("reset busy", busy, 0);
        check("reset wready_m", WREADY_M, 0);
        check("reset wvalid_s", WVALID_S, 0);
        check("reset last_err", last_err, 0);
        check("reset dec_err", dec_err, 0);
        next_cycle();

`ifndef AXI_W_SKID_EN
        // sel=1 len=3 clean burst; sel=0 len=1 with early WLAST; sel=5 sink burst
        tbl.push_back(mk(1, 1, 3, 0, 0, 2'b11, 32'h0,  1, 0, 2'b00, 2'b00, 64'h0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 2'b11, 32'hA0, 0, 1, 2'b10, 2'b00, 64'hA0_0000_0000, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 2'b11, 32'hA1, 0, 1, 2'b10, 2'b00, 64'hA1_0000_0000, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 2'b11, 32'hA2, 0, 1, 2'b10, 2'b00, 64'hA2_0000_0000, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 2'b11, 32'hA3, 0, 1, 2'b10, 2'b10, 64'hA3_0000_0000, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 2'b11, 32'h0,  1, 0, 2'b00, 2'b00, 64'h0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 2'b11, 32'h0,  1, 0, 2'b00, 2'b00, 64'h0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 2'b11, 32'hB0, 0, 1, 2'b01, 2'b00, 64'hB0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 2'b11, 32'hB1, 0, 1, 2'b01, 2'b01, 64'hB1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 2'b11, 32'h0,  1, 0, 2'b00, 2'b00, 64'h0, 0, 0, 0));
        tbl.push_back(mk(1, 5, 0, 0, 0, 2'b00, 32'h0,  1, 0, 2'b00, 2'b00, 64'h0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 2'b00, 32'hC0, 0, 1, 2'b00, 2'b00, 64'h0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 2'b00, 32'h0,  1, 0, 2'b00, 2'b00, 64'h0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 2'b00, 32'h0,  1, 0, 2'b00, 2'b00, 64'h0, 0, 0, 0));

        foreach (tbl[k]) begin
            set_in(tbl[k].av, tbl[k].sel, tbl[k].len, tbl[k].wv, tbl[k].wl, tbl[k].rs,
                   tbl[k].data);
            #1;
            check($sformatf("row%0d aw_ready", k), aw_ready, tbl[k].e_awr);
            check($sformatf("row%0d wready_m", k), WREADY_M, tbl[k].e_wrm);
            check($sformatf("row%0d wvalid_s", k), WVALID_S, tbl[k].e_wvs);
            check($sformatf("row%0d wlast_s", k), WLAST_S, tbl[k].e_wls);
            check($sformatf("row%0d wdata_s", k), WDATA_S, tbl[k].e_wds);
            check($sformatf("row%0d busy", k), busy, tbl[k].e_busy);
            check($sformatf("row%0d last_err", k), last_err, tbl[k].e_lerr);
            check($sformatf("row%0d dec_err", k), dec_err, tbl[k].e_derr);
            next_cycle();
        end

        // Slave 0 stalls for three cycles in the middle of a 4-beat burst
        set_in(1, 0, 3, 0, 0, 2'b01, 32'h0);
        next_cycle();
        set_in(0, 0, 3, 1, 0, 2'b01, 32'hD0);
        #1;
        check("stall beat0 wready_m", WREADY_M, 1);
        next_cycle();
        for (int c = 0; c < 3; c++) begin
            set_in(0, 0, 3, 1, 0, 2'b00, 32'hD1);
            #1;
            check($sformatf("stall%0d wready_m", c), WREADY_M, 0);
            check($sformatf("stall%0d wdata_s0", c), WDATA_S[31:0], 32'hD1);
            check($sformatf("stall%0d wvalid_s", c), WVALID_S, 2'b01);
            next_cycle();
        end
        for (int b = 1; b < 4; b++) begin
            set_in(0, 0, 3, 1, (b == 3), 2'b01, 32'(32'hD0 + b));
            #1;
            check($sformatf("stall beat%0d wready_m", b), WREADY_M, 1);
            check($sformatf("stall beat%0d wlast_s", b), WLAST_S, (b == 3) ? 2'b01 : 2'b00);
            next_cycle();
        end
        set_in(0, 0, 0, 0, 0, 2'b00, 32'h0);
        #1;
        check("stall end busy", busy, 0);
        check("stall end last_err", last_err, 0);
        next_cycle();

        // Reset lands mid-burst on a beat whose WLAST_M would raise last_err
        set_in(1, 1, 3, 0, 0, 2'b11, 32'h0);
        next_cycle();
        for (int b = 0; b < 2; b++) begin
            set_in(0, 1, 3, 1, 0, 2'b11, 32'(32'h50 + b));
            next_cycle();
        end
        set_in(0, 1, 3, 1, 1, 2'b11, 32'h52);
        ARESET = 1'b1;
        next_cycle();
        ARESET = 1'b0;
        set_in(0, 0, 0, 0, 0, 2'b00, 32'h0);
        #1;
        check("rst mid aw_ready", aw_ready, 1);
        check("rst mid busy", busy, 0);
        check("rst mid last_err", last_err, 0);
        check("rst mid dec_err", dec_err, 0);
        next_cycle();
        check("rst after last_err", last_err, 0);
        check("rst after busy", busy, 0);

        // Randomized traffic against the burst-level model
        m_busy = 0; m_perr = 0; m_pdec = 0; m_tgt = 0; m_nbeats = 1; m_done = 0;
        for (int n = 0; n < 600; n++) begin
            aw_valid = ($urandom_range(0, 3) == 0);
            aw_sel   = 3'($urandom_range(0, 3));
            aw_len   = 4'($urandom_range(0, 5));
            WVALID_M = ($urandom_range(0, 3) != 0);
            WLAST_M  = 1'($urandom_range(0, 1));
            WREADY_S = 2'($urandom);
            WDATA_M  = $urandom;
            WSTRB_M  = 4'($urandom);
            #1;
            final_b = m_busy && (m_done + 1 == m_nbeats);
            e_wrm = 0; e_wvs = 0; e_wls = 0; e_wd = 0; e_ws = 0;
            if (m_busy) begin
                if (m_tgt < NUM_S) begin
                    e_wrm = WREADY_S[m_tgt];
                    e_wvs = 2'(WVALID_M) << m_tgt;
                    e_wls = 2'(final_b) << m_tgt;
                    e_wd  = 64'(WDATA_M) << (32 * m_tgt);
                    e_ws  = 8'(WSTRB_M) << (4 * m_tgt);
                end else begin
                    e_wrm = 1;
                end
            end
            check("rnd aw_ready", aw_ready, !m_busy);
            check("rnd busy", busy, m_busy);
            check("rnd wready_m", WREADY_M, e_wrm);
            check("rnd wvalid_s", WVALID_S, e_wvs);
            check("rnd wlast_s", WLAST_S, e_wls);
            check("rnd wdata_s", WDATA_S, e_wd);
            check("rnd wstrb_s", WSTRB_S, e_ws);
            check("rnd last_err", last_err, m_perr);
            check("rnd dec_err", dec_err, m_pdec);
            hs     = m_busy && WVALID_M && e_wrm;
            m_perr = hs && (WLAST_M != final_b);
            m_pdec = hs && final_b && (m_tgt >= NUM_S);
            if (hs) begin
                m_done++;
                if (final_b) m_busy = 0;
            end else if (!m_busy && aw_valid) begin
                m_busy   = 1;
                m_tgt    = int'(aw_sel);
                m_nbeats = int'(aw_len) + 1;
                m_done   = 0;
            end
            next_cycle();
        end
`else
        begin
            int acc, rx, final_cyc;
            acc = 0; rx = 0; final_cyc = -1;
            set_in(1, 0, 3, 0, 0, 2'b00, 32'h0);
            next_cycle();
            // Slave stuck: only two beats fit in the buffer
            for (int c = 0; c < 4; c++) begin
                set_in(0, 0, 3, 1, (acc == 3), 2'b00, 32'(32'hE0 + acc));
                #1;
                if (c == 3) check("skid full wready_m", WREADY_M, 0);
                if (WVALID_M && WREADY_M) acc++;
                next_cycle();
            end
            check("skid accepted before stall", acc, 2);
            for (int c = 0; c < 20; c++) begin
                set_in(0, 0, 3, (acc < 4), (acc == 3), 2'b01, 32'(32'hE0 + acc));
                #1;
                if (c == final_cyc) begin
                    check("drain busy", busy, 1);
                    check("drain wready_m", WREADY_M, 0);
                end
                if (WVALID_S[0]) begin
                    check($sformatf("skid data%0d", rx), WDATA_S[31:0], 32'(32'hE0 + rx));
                    check($sformatf("skid last%0d", rx), WLAST_S[0], (rx == 3));
                    rx++;
                end
                if (WVALID_M && WREADY_M) begin
                    acc++;
                    if (acc == 4) final_cyc = c + 1;
                end
                next_cycle();
            end
            check("skid beats accepted", acc, 4);
            check("skid beats delivered", rx, 4);
            check("skid end busy", busy, 0);
            check("skid end aw_ready", aw_ready, 1);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/axi_w_router.md
AXI_W_ROUTER -- requirements
Module: axi_w_router

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter NUM_S, default 2, SHALL set the number of slave write-data ports (range 1..8).
REQ-003 Parameter DATA_W, default 32, SHALL set the data width; the strobe width SHALL be DATA_W/8.
REQ-004 Parameter LEN_W, default 4, SHALL set the burst-length field width.
REQ-005 The ports SHALL be, in order:
- ACLK  in  1  clock.
- ARESET  in  1  synchronous active-high reset.
- aw_valid  in  1  routing request from the address channel.
- aw_sel  in  3  target slave index.
- aw_len  in  LEN_W  beats minus 1.
- aw_ready  out  1  router can accept a routing request.
- WDATA_M  in  DATA_W  master data.
- WSTRB_M  in  DATA_W/8  master strobe.
- WLAST_M  in  1  master last.
- WVALID_M  in  1  master valid.
- WREADY_M  out  1  master ready.
- WDATA_S  out  NUM_S*DATA_W  per-slave data.
- WSTRB_S  out  NUM_S*DATA_W/8  per-slave strobe.
- WLAST_S  out  NUM_S  per-slave last.
- WVALID_S  out  NUM_S  per-slave valid.
- WREADY_S  in  NUM_S  per-slave ready.
- busy  out  1  burst in progress.
- last_err  out  1  one-cycle pulse: WLAST_M disagrees with the beat count.
- dec_err  out  1  one-cycle pulse: burst to an invalid slave completed.

Function
REQ-006 The FSM SHALL have three states: IDLE, ACTIVE, DRAIN; encodings SHALL be 0, 1, 2.
REQ-007 aw_ready SHALL be 1 only in IDLE; a routing request is accepted when aw_valid and aw_ready are both 1.
REQ-008 On acceptance, the block SHALL latch aw_sel and aw_len, clear the beat counter, and enter ACTIVE on the next cycle.
REQ-009 In IDLE, WREADY_M and all WVALID_S SHALL be 0, and all slave data, strobe and last outputs SHALL be 0.
REQ-010 In ACTIVE with a valid target (sel < NUM_S), the selected slave SHALL receive the master's data, strobe and valid, and WREADY_M SHALL equal that slave's WREADY_S; all unselected slave outputs SHALL be 0.
REQ-011 WLAST to the slave SHALL be generated by the router as (beat count == latched len); WLAST_M SHALL NOT be forwarded.
REQ-012 Each master-side handshake (WVALID_M and WREADY_M) SHALL increment the beat counter, which wraps modulo 2^LEN_W.
REQ-013 On a handshake where the WLAST_M value differs from the generated last, last_err SHALL pulse 1 in the following cycle.
REQ-014 If sel >= NUM_S, the block SHALL be in sink mode: WREADY_M=1, every beat dropped, no WVALID_S asserted, and dec_err pulsed in the cycle after the final beat.
REQ-015 On the final-beat handshake, the block SHALL go to IDLE, or to DRAIN when the skid buffer is non-empty; DRAIN SHALL go to IDLE once the buffer is empty.
REQ-016 busy SHALL be 1 in ACTIVE and DRAIN, and 0 in IDLE.
REQ-017 A new routing request SHALL never be accepted in the same cycle as a final beat; it waits one cycle in IDLE.

Reset
REQ-018 Reset SHALL force state to IDLE and clear the counter, latched sel/len, skid buffer, last_err and dec_err; a burst in flight SHALL be abandoned without pulses.

Configuration
REQ-019 With AXI_W_SKID_EN defined:
- a 2-entry skid buffer SHALL register the path to the slaves (1-cycle latency);
- WREADY_M SHALL be 1 whenever the buffer has a free entry.
REQ-020 Without AXI_W_SKID_EN, the path SHALL be combinational with zero latency, and DRAIN SHALL be unreachable.

Structure
REQ-021 The state enum, the LEN_W default and the sel width SHALL live in the shared AXI package next to the AXI_* width defines.
REQ-022 The skid buffer SHALL be a sub-module, axi_w_skid, instantiated only under AXI_W_SKID_EN.

Verification
REQ-023 Scenario 1: NUM_S=2, aw_sel=1, aw_len=3, four beats 0xA0..0xA3 with WLAST_M on beat 4 -> slave 1 receives 4 beats with WLAST on 0xA3; slave 0 outputs all 0; last_err=0.
REQ-024 Scenario 2: WREADY_S[0] held 0 for 3 cycles mid-burst -> WREADY_M=0 for those 3 cycles, and the data is held stable.
REQ-025 Scenario 3: aw_len=1 with WLAST_M asserted on beat 1 -> last_err pulses once; the burst ends after beat 2.
REQ-026 Scenario 4: aw_sel=5 with NUM_S=2, aw_len=0 -> the beat is accepted, no WVALID_S is asserted, and dec_err pulses once.
REQ-027 Scenario 5: ARESET asserted after beat 2 of 4 -> next cycle state=IDLE, aw_ready=1, busy=0, no pulses.
REQ-028 Scenario 6 (AXI_W_SKID_EN): back-to-back 4-beat burst with slave ready stuck at 0 -> WREADY_M drops after 2 beats, and the final state passes through DRAIN.
